// File: rtl/pwm_seq_scheduler.sv
// pwm_seq_scheduler
//   Launches PWM/DAC pattern channels one at a time in a programmed slot
//   order. An idle gap is inserted between launches, and the whole order is
//   repeated for a programmed number of passes. Configuration is copied into
//   shadow registers when a start is accepted, so it cannot change while a
//   sequence runs.
//
//   Optional feature, enabled by defining PWM_SEQ_TIMEOUT_EN:
//     If a launched channel does not raise busy within _TO_CYCLES cycles, the
//     sequence is abandoned and the sticky seq_err flag is set.
//
// Ports
//   clk_50M    : system clock
//   rst        : synchronous, active-high reset
//   seq_start  : single-cycle start pulse (accepted only in IDLE)
//   seq_abort  : abort request, level; returns to IDLE with no seq_done
//   seq_order  : slot k channel index at [k*_IDX_W +: _IDX_W]
//   seq_len    : slots per pass, valid range 1.._NUM_CHANNELS
//   gap_cycles : extra idle cycles between launches
//   loop_num   : number of passes, 0 = run until abort
//   pwm_busy   : busy flags from the channels
//   pwm_en     : registered channel enables, at most one bit high
//   seq_busy   : high while a sequence is running
//   seq_done   : one-cycle pulse on normal completion
//   cur_slot   : slot currently being served
//   cur_loop   : completed-pass count
//   seq_err    : sticky busy-rise timeout flag (0 without PWM_SEQ_TIMEOUT_EN)
module pwm_seq_scheduler #(
    parameter int unsigned _NUM_CHANNELS = 4,
    parameter int unsigned _IDX_W        = 2,
    parameter int unsigned _GAP_WIDTH    = 16,
    parameter int unsigned _TO_CYCLES    = 1023
) (
    input  logic                              clk_50M,
    input  logic                              rst,
    input  logic                              seq_start,
    input  logic                              seq_abort,
    input  logic [_NUM_CHANNELS*_IDX_W-1:0]   seq_order,
    input  logic [7:0]                        seq_len,
    input  logic [_GAP_WIDTH-1:0]             gap_cycles,
    input  logic [7:0]                        loop_num,
    input  logic [_NUM_CHANNELS-1:0]          pwm_busy,
    output logic [_NUM_CHANNELS-1:0]          pwm_en,
    output logic                              seq_busy,
    output logic                              seq_done,
    output logic [7:0]                        cur_slot,
    output logic [7:0]                        cur_loop,
    output logic                              seq_err
);

    localparam int unsigned OW = _NUM_CHANNELS * _IDX_W;

    typedef enum logic [2:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP, DONE} state_t;

    state_t                    state_q, state_d;
    logic [_NUM_CHANNELS-1:0]  en_q, en_d;
    logic [OW-1:0]             order_q, order_d;
    logic [7:0]                len_q, len_d;
    logic [7:0]                loops_q, loops_d;
    logic [_GAP_WIDTH-1:0]     gap_q, gap_d;
    logic [_GAP_WIDTH-1:0]     cnt_q, cnt_d;
    logic [7:0]                slot_q, slot_d;
    logic [7:0]                loop_q, loop_d;

    logic                      launch;
    logic [_NUM_CHANNELS-1:0]  launch_oh;
    logic [_GAP_WIDTH-1:0]     launch_gap;
    logic [_NUM_CHANNELS-1:0]  cur_oh;
    logic                      cur_busy;
    logic [7:0]                loop_inc;

`ifdef PWM_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(_TO_CYCLES + 1);
    logic [TO_W-1:0]           to_q, to_d;
    logic                      err_q, err_d;
    logic                      to_hit;
    assign to_hit = (to_q == TO_W'(_TO_CYCLES - 1));
`endif

    // One-hot enable for the channel in a slot; all-zero when the stored
    // index names no existing channel (such slots are skipped).
    function automatic logic [_NUM_CHANNELS-1:0] slot_onehot(
        input logic [OW-1:0] order,
        input logic [7:0]    slot
    );
        logic [_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned k = 0; k < _NUM_CHANNELS; k++)
            if (slot == 8'(k))
                idx = order[k*_IDX_W +: _IDX_W];
        slot_onehot = '0;
        for (int unsigned c = 0; c < _NUM_CHANNELS; c++)
            slot_onehot[c] = (idx == _IDX_W'(c));
    endfunction

    assign cur_oh   = slot_onehot(order_q, slot_q);
    assign cur_busy = |(pwm_busy & cur_oh);
    assign loop_inc = loop_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        order_d    = order_q;
        len_d      = len_q;
        loops_d    = loops_q;
        gap_d      = gap_q;
        cnt_d      = cnt_q;
        slot_d     = slot_q;
        loop_d     = loop_q;
        launch     = 1'b0;
        launch_oh  = '0;
        launch_gap = gap_q;
`ifdef PWM_SEQ_TIMEOUT_EN
        to_d       = to_q;
        err_d      = err_q;
`endif
        if (state_q != IDLE && seq_abort) begin
            en_d    = '0;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (seq_start && !seq_abort && seq_len != 8'd0 &&
                        seq_len <= 8'(_NUM_CHANNELS)) begin
                        order_d    = seq_order;
                        len_d      = seq_len;
                        gap_d      = gap_cycles;
                        loops_d    = loop_num;
                        slot_d     = '0;
                        loop_d     = '0;
`ifdef PWM_SEQ_TIMEOUT_EN
                        err_d      = 1'b0;
`endif
                        launch     = 1'b1;
                        launch_oh  = slot_onehot(seq_order, 8'd0);
                        launch_gap = gap_cycles;
                    end
                end
                WAIT_BUSY: begin
                    if (cur_busy)
                        state_d = WAIT_DONE;
`ifdef PWM_SEQ_TIMEOUT_EN
                    else if (to_hit) begin
                        err_d   = 1'b1;
                        en_d    = '0;
                        state_d = IDLE;
                    end else
                        to_d = to_q + TO_W'(1);
`endif
                end
                // GAP is entered even when gap_cycles is 0: the advance then
                // happens one edge later, which keeps pwm_en low for exactly
                // gap_cycles+1 cycles, also between launches of one channel.
                WAIT_DONE: begin
                    if (!cur_busy) begin
                        en_d    = '0;
                        cnt_d   = gap_q;
                        state_d = GAP;
                    end
                end
                GAP: begin
                    if (cnt_q != '0)
                        cnt_d = cnt_q - _GAP_WIDTH'(1);
                    else if (slot_q < len_q - 8'd1) begin
                        slot_d    = slot_q + 8'd1;
                        launch    = 1'b1;
                        launch_oh = slot_onehot(order_q, slot_q + 8'd1);
                    end else begin
                        loop_d = loop_inc;
                        if (loops_q != 8'd0 && loop_inc == loops_q)
                            state_d = DONE;
                        else begin
                            slot_d    = '0;
                            launch    = 1'b1;
                            launch_oh = slot_onehot(order_q, 8'd0);
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase

            // A slot naming no channel launches nothing; it is treated as
            // completed immediately and only its gap is served.
            if (launch) begin
                en_d = launch_oh;
                if (launch_oh != '0) begin
                    state_d = WAIT_BUSY;
`ifdef PWM_SEQ_TIMEOUT_EN
                    to_d    = '0;
`endif
                end else begin
                    cnt_d   = launch_gap;
                    state_d = GAP;
                end
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_q <= IDLE;
            en_q    <= '0;
            order_q <= '0;
            len_q   <= '0;
            loops_q <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            slot_q  <= '0;
            loop_q  <= '0;
`ifdef PWM_SEQ_TIMEOUT_EN
            to_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            order_q <= order_d;
            len_q   <= len_d;
            loops_q <= loops_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            loop_q  <= loop_d;
`ifdef PWM_SEQ_TIMEOUT_EN
            to_q    <= to_d;
            err_q   <= err_d;
`endif
        end
    end

    assign pwm_en   = en_q;
    assign seq_busy = (state_q != IDLE) && (state_q != DONE);
    assign seq_done = (state_q == DONE);
    assign cur_slot = slot_q;
    assign cur_loop = loop_q;
`ifdef PWM_SEQ_TIMEOUT_EN
    assign seq_err  = err_q;
`else
    assign seq_err  = 1'b0;
`endif

endmodule
